mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Parametrised successor to the pipeline memory-access stage.
- Adds sub-word loads and stores (LB/LBU/LH/LHU/LW/SB/SH/SW) with byte enables and sign/zero extension.
- Talks to a variable-latency data memory over a req/ack handshake, stalls the upstream pipeline while an access is in flight, detects misaligned and timed-out accesses, and registers the MEM/WB result.
- Sits between EX/MEM and the writeback stage; HI/LO results pass through unchanged.

Parameters:
ADDR_W, 32, data memory byte-address width
REG_ADDR_W, 5, register file address width
TIMEOUT_CYC, 255, BUSY cycles allowed without ack before bus error; 0 disables timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
in_valid  in  1  EX/MEM entry valid this cycle
data_in  in  32  ALU result
reg_write_en_in  in  1  writeback enable
reg_addr_in  in  REG_ADDR_W  destination register
mem_op_in  in  4  0001 LB, 0010 LBU, 0011 LH, 0100 LHU, 0101 LW, 1001 SB, 1010 SH, 1011 SW, other = none
mem_addr_in  in  ADDR_W  byte address
mem_write_data_in  in  32  store data, right-aligned
hilo_write_en_in  in  1  HI/LO write enable
hi_in, lo_in  in  32 each  HI/LO values
stall_out  out  1  upstream must hold; inputs ignored while high
dmem_req  out  1  memory request
dmem_we  out  1  1 = store
dmem_be  out  4  byte enables
dmem_addr  out  ADDR_W  word-aligned address, low 2 bits zero
dmem_wdata  out  32  lane-replicated store data
dmem_ack  in  1  request complete; rdata valid this cycle for loads
dmem_rdata  in  32  read word
out_valid  out  1  MEM/WB entry valid
data_out  out  32  writeback data
reg_write_en_out  out  1  writeback enable
reg_addr_out  out  REG_ADDR_W  destination register
hilo_write_en  out  1  HI/LO write enable
hi_out, lo_out  out  32 each  HI/LO values
addr_err  out  1  one-cycle pulse with out_valid: misaligned access
bus_err  out  1  one-cycle pulse with out_valid: timeout

Behaviour:
- Reset (rst=0, async):
  - State IDLE, timeout counter 0.
  - Every output 0, including dmem_req and stall_out.
  - Reset during BUSY aborts the access immediately; no result is produced.
- Byte ordering: little-endian. Byte at addr[1:0]=k occupies bits 8k+7:8k.
- FSM states: IDLE, BUSY.
  - stall_out = (state==BUSY).
  - dmem_req = (state==BUSY); dmem_we, dmem_be, dmem_addr and dmem_wdata are driven from latched fields and held stable while BUSY.
- IDLE, in_valid=0: next cycle carries a bubble (out_valid=0, reg_write_en_out=0, hilo_write_en=0, errors 0).
- IDLE, in_valid=1, no mem op: all fields registered. Next cycle out_valid=1 and data_out=data_in (1-cycle latency).
- IDLE, in_valid=1, misaligned op (halfword with addr[0]=1, word with addr[1:0]!=0):
  - No request is issued.
  - Next cycle out_valid=1, addr_err=1, reg_write_en_out=0, hilo_write_en=0.
- IDLE, in_valid=1, aligned mem op: latch all fields, go to BUSY, reset counter.
- Byte enables and store data:
  - Byte ops: be = 0001 shifted left by addr[1:0].
  - Halfword ops: be = 0011 shifted left by addr[1:0].
  - Word ops: be = 1111.
  - dmem_wdata: byte replicated 4x, halfword replicated 2x, word as-is.
- BUSY with dmem_ack=1:
  - Return to IDLE; output registers load at that edge.
  - Loads: data_out is the selected lane, sign-extended (LB/LH) or zero-extended (LBU/LHU).
  - Stores: data_out = latched data_in.
  - Minimum memory-op latency is 2 cycles from accept to out_valid.
- BUSY without ack: counter increments each cycle.
  - If TIMEOUT_CYC!=0 and the counter reaches TIMEOUT_CYC: drop to IDLE. Next cycle out_valid=1, bus_err=1, reg_write_en_out=0, hilo_write_en=0.
  - If ack arrives in the same cycle the counter reaches TIMEOUT_CYC, ack wins.
- dmem_ack while IDLE is ignored.
- Inputs presented while stall_out=1 are ignored.
- The IDLE cycle after completion may accept new input (back-to-back throughput: one memory op per 2 cycles minimum).
- out_valid, addr_err and bus_err are single-cycle pulses per accepted entry.

Test Plan:
- Reset mid-BUSY: LW issued, rst=0 before ack -> dmem_req and stall_out drop asynchronously; no out_valid after rst=1.
- ALU pass-through: in_valid, data_in=0x1234_5678, reg_addr 5, op none -> next cycle out_valid=1, data_out=0x1234_5678, reg_addr_out=5, no dmem_req.
- Load extension:
  - LB at addr 0x...3 with rdata=0x80FF_0000 -> data_out=0xFFFF_FF80, be=1000.
  - LBU, same address and rdata -> 0x0000_0080.
  - LH at addr 0x...2 with rdata=0x8001_0000 -> 0xFFFF_8001.
- Store lanes: SH at addr 0x...2 with data 0xABCD -> dmem_we=1, be=1100, wdata=0xABCD_ABCD; ack after 3 cycles -> stall_out high 3 cycles, out_valid next cycle.
- Misaligned: LW at 0x...2 -> no dmem_req, next cycle addr_err=1, reg_write_en_out=0.
- Timeout: TIMEOUT_CYC=4, SW with ack never given -> req held 4 cycles, then bus_err=1 with out_valid. Repeat with ack on the 4th cycle -> normal completion, bus_err=0.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// Bundles the EX/MEM inputs, the data-memory req/ack bus and the MEM/WB outputs of the memory stage.
// slave = the memory stage itself; master = whatever surrounds it (pipeline, memory, testbench).
interface mem_stage_lsu_if #(
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5
);
  // EX/MEM side
  logic                  in_valid;
  logic [31:0]           data_in;
  logic                  reg_write_en_in;
  logic [REG_ADDR_W-1:0] reg_addr_in;
  logic [3:0]            mem_op_in;
  logic [ADDR_W-1:0]     mem_addr_in;
  logic [31:0]           mem_write_data_in;
  logic                  hilo_write_en_in;
  logic [31:0]           hi_in;
  logic [31:0]           lo_in;
  logic                  stall_out;

  // data memory side
  logic                  dmem_req;
  logic                  dmem_we;
  logic [3:0]            dmem_be;
  logic [ADDR_W-1:0]     dmem_addr;
  logic [31:0]           dmem_wdata;
  logic                  dmem_ack;
  logic [31:0]           dmem_rdata;

  // MEM/WB side
  logic                  out_valid;
  logic [31:0]           data_out;
  logic                  reg_write_en_out;
  logic [REG_ADDR_W-1:0] reg_addr_out;
  logic                  hilo_write_en;
  logic [31:0]           hi_out;
  logic [31:0]           lo_out;
  logic                  addr_err;
  logic                  bus_err;

  modport slave (
    input  in_valid, data_in, reg_write_en_in, reg_addr_in, mem_op_in, mem_addr_in,
           mem_write_data_in, hilo_write_en_in, hi_in, lo_in, dmem_ack, dmem_rdata,
    output stall_out, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
           out_valid, data_out, reg_write_en_out, reg_addr_out, hilo_write_en,
           hi_out, lo_out, addr_err, bus_err
  );

  modport master (
    output in_valid, data_in, reg_write_en_in, reg_addr_in, mem_op_in, mem_addr_in,
           mem_write_data_in, hilo_write_en_in, hi_in, lo_in, dmem_ack, dmem_rdata,
    input  stall_out, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
           out_valid, data_out, reg_write_en_out, reg_addr_out, hilo_write_en,
           hi_out, lo_out, addr_err, bus_err
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory stage: registers ALU/HI-LO results into MEM/WB and runs sub-word loads/stores over req/ack.
// Latency 1 cycle without memory, >=2 with memory; stall_out holds upstream for the whole BUSY period.
module mem_stage_lsu #(
  parameter int ADDR_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic           clk,
  input  logic           rst,
  mem_stage_lsu_if.slave bus
);

  localparam int              CNT_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit              TO_EN    = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t state_q, state_d;

  logic in_ld, in_st, in_byte, in_half, in_word, in_sgn, in_misal;
  logic busy, accept, start, ack_done, to_hit;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;

  // fields latched for the duration of a memory access
  logic                  we_q, ld_q, byte_q, half_q, sgn_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q;
  logic [ADDR_W-1:0]     waddr_q;
  logic [1:0]            off_q;
  logic [31:0]           data_q, hi_q, lo_q;
  logic                  rwe_q, hwe_q;
  logic [REG_ADDR_W-1:0] raddr_q;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] lane, ld_val;

  // MEM/WB register
  logic                  out_valid_q, out_valid_d;
  logic [31:0]           data_out_q, data_out_d;
  logic                  rwe_out_q, rwe_out_d;
  logic [REG_ADDR_W-1:0] raddr_out_q, raddr_out_d;
  logic                  hwe_out_q, hwe_out_d;
  logic [31:0]           hi_out_q, hi_out_d;
  logic [31:0]           lo_out_q, lo_out_d;
  logic                  aerr_q, aerr_d;
  logic                  berr_q, berr_d;

  always_comb begin
    in_ld   = 1'b0;
    in_st   = 1'b0;
    in_byte = 1'b0;
    in_half = 1'b0;
    in_word = 1'b0;
    in_sgn  = 1'b0;
    case (bus.mem_op_in)
      4'b0001: begin in_ld = 1'b1; in_byte = 1'b1; in_sgn = 1'b1; end
      4'b0010: begin in_ld = 1'b1; in_byte = 1'b1; end
      4'b0011: begin in_ld = 1'b1; in_half = 1'b1; in_sgn = 1'b1; end
      4'b0100: begin in_ld = 1'b1; in_half = 1'b1; end
      4'b0101: begin in_ld = 1'b1; in_word = 1'b1; end
      4'b1001: begin in_st = 1'b1; in_byte = 1'b1; end
      4'b1010: begin in_st = 1'b1; in_half = 1'b1; end
      4'b1011: begin in_st = 1'b1; in_word = 1'b1; end
      default: ;
    endcase
  end

  assign in_misal = (in_half & bus.mem_addr_in[0]) |
                    (in_word & (bus.mem_addr_in[1:0] != 2'b00));
  assign busy     = (state_q == BUSY);
  assign accept   = (state_q == IDLE) & bus.in_valid;
  assign start    = accept & (in_ld | in_st) & ~in_misal;
  assign ack_done = busy & bus.dmem_ack;
  // an ack in the final allowed cycle takes priority over the timeout
  assign to_hit   = busy & ~bus.dmem_ack & TO_EN & (cnt_q == CNT_LAST);

  always_comb begin
    be_in    = 4'b1111;
    wdata_in = bus.mem_write_data_in;
    if (in_byte) begin
      be_in    = 4'b0001 << bus.mem_addr_in[1:0];
      wdata_in = {4{bus.mem_write_data_in[7:0]}};
    end else if (in_half) begin
      be_in    = 4'b0011 << bus.mem_addr_in[1:0];
      wdata_in = {2{bus.mem_write_data_in[15:0]}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      ld_q    <= 1'b0;
      byte_q  <= 1'b0;
      half_q  <= 1'b0;
      sgn_q   <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      off_q   <= '0;
      data_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rwe_q   <= 1'b0;
      hwe_q   <= 1'b0;
      raddr_q <= '0;
    end else if (start) begin
      we_q    <= in_st;
      ld_q    <= in_ld;
      byte_q  <= in_byte;
      half_q  <= in_half;
      sgn_q   <= in_sgn;
      be_q    <= be_in;
      wdata_q <= wdata_in;
      waddr_q <= {bus.mem_addr_in[ADDR_W-1:2], 2'b00};
      off_q   <= bus.mem_addr_in[1:0];
      data_q  <= bus.data_in;
      hi_q    <= bus.hi_in;
      lo_q    <= bus.lo_in;
      rwe_q   <= bus.reg_write_en_in;
      hwe_q   <= bus.hilo_write_en_in;
      raddr_q <= bus.reg_addr_in;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (busy && !bus.dmem_ack) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // little-endian lane select, then sign or zero extension
  assign lane = bus.dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    if (byte_q)      ld_val = {{24{sgn_q & lane[7]}}, lane[7:0]};
    else if (half_q) ld_val = {{16{sgn_q & lane[15]}}, lane[15:0]};
    else             ld_val = lane;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (ack_done || to_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.stall_out  = busy;
    bus.dmem_req   = busy;
    bus.dmem_we    = busy & we_q;
    bus.dmem_be    = busy ? be_q : 4'b0000;
    bus.dmem_addr  = busy ? waddr_q : '0;
    bus.dmem_wdata = busy ? wdata_q : '0;
  end

  always_comb begin
    out_valid_d = 1'b0;
    data_out_d  = data_out_q;
    rwe_out_d   = 1'b0;
    raddr_out_d = raddr_out_q;
    hwe_out_d   = 1'b0;
    hi_out_d    = hi_out_q;
    lo_out_d    = lo_out_q;
    aerr_d      = 1'b0;
    berr_d      = 1'b0;
    if (accept && !(in_ld || in_st)) begin
      out_valid_d = 1'b1;
      data_out_d  = bus.data_in;
      rwe_out_d   = bus.reg_write_en_in;
      raddr_out_d = bus.reg_addr_in;
      hwe_out_d   = bus.hilo_write_en_in;
      hi_out_d    = bus.hi_in;
      lo_out_d    = bus.lo_in;
    end else if (accept && in_misal) begin
      out_valid_d = 1'b1;
      aerr_d      = 1'b1;
      data_out_d  = bus.data_in;
      raddr_out_d = bus.reg_addr_in;
      hi_out_d    = bus.hi_in;
      lo_out_d    = bus.lo_in;
    end else if (ack_done) begin
      out_valid_d = 1'b1;
      data_out_d  = ld_q ? ld_val : data_q;
      rwe_out_d   = rwe_q;
      raddr_out_d = raddr_q;
      hwe_out_d   = hwe_q;
      hi_out_d    = hi_q;
      lo_out_d    = lo_q;
    end else if (to_hit) begin
      out_valid_d = 1'b1;
      berr_d      = 1'b1;
      data_out_d  = data_q;
      raddr_out_d = raddr_q;
      hi_out_d    = hi_q;
      lo_out_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      rwe_out_q   <= 1'b0;
      raddr_out_q <= '0;
      hwe_out_q   <= 1'b0;
      hi_out_q    <= '0;
      lo_out_q    <= '0;
      aerr_q      <= 1'b0;
      berr_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      rwe_out_q   <= rwe_out_d;
      raddr_out_q <= raddr_out_d;
      hwe_out_q   <= hwe_out_d;
      hi_out_q    <= hi_out_d;
      lo_out_q    <= lo_out_d;
      aerr_q      <= aerr_d;
      berr_q      <= berr_d;
    end
  end

  assign bus.out_valid        = out_valid_q;
  assign bus.data_out         = data_out_q;
  assign bus.reg_write_en_out = rwe_out_q;
  assign bus.reg_addr_out     = raddr_out_q;
  assign bus.hilo_write_en    = hwe_out_q;
  assign bus.hi_out           = hi_out_q;
  assign bus.lo_out           = lo_out_q;
  assign bus.addr_err         = aerr_q;
  assign bus.bus_err          = berr_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed vectors for mem_stage_lsu; expected MEM/WB entries queue up and a negedge monitor retires them.
module tb_mem_stage_lsu;

  logic clk;
  logic rst;

  mem_stage_lsu_if #(.ADDR_W(32), .REG_ADDR_W(5)) bus ();

  mem_stage_lsu #(.ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT_CYC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr, wd, din;
    logic        rwe;
    logic [4:0]  ra;
    logic        hwe;
    logic [31:0] hi, lo;
    int          ack_at;
    logic [31:0] rdata;
    logic [3:0]  ebe;
    logic [31:0] ewd, eaddr;
    logic        ewe;
    logic [31:0] edata;
    logic        erwe, ehwe, eaerr, eberr;
    int          ebusy;
    logic        full;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] data, hi, lo;
    logic [4:0]  raddr;
    logic        rwe, hwe, aerr, berr, full;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vq[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(
    input logic [3:0] op, input logic [31:0] addr, wd, din, input logic rwe, input logic [4:0] ra,
    input logic hwe, input logic [31:0] hi, lo, input int ack_at, input logic [31:0] rdata,
    input logic [3:0] ebe, input logic [31:0] ewd, eaddr, input logic ewe, input logic [31:0] edata,
    input logic erwe, ehwe, eaerr, eberr, input int ebusy, input logic full);
    vec_t v;
    v.op = op; v.addr = addr; v.wd = wd; v.din = din; v.rwe = rwe; v.ra = ra;
    v.hwe = hwe; v.hi = hi; v.lo = lo; v.ack_at = ack_at; v.rdata = rdata;
    v.ebe = ebe; v.ewd = ewd; v.eaddr = eaddr; v.ewe = ewe; v.edata = edata;
    v.erwe = erwe; v.ehwe = ehwe; v.eaerr = eaerr; v.eberr = eberr; v.ebusy = ebusy; v.full = full;
    return v;
  endfunction

  // monitor: every out_valid retires one expected entry; otherwise the side-band flags must be quiet
  always @(negedge clk) begin
    if (rst) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_out_valid: got out_valid=1 data_out=0x%08h, expected no entry", bus.data_out);
        end else begin
          mon_e = exp_q.pop_front();
          chk($sformatf("v%0d_reg_we", mon_e.id), 32'(bus.reg_write_en_out), 32'(mon_e.rwe));
          chk($sformatf("v%0d_hilo_we", mon_e.id), 32'(bus.hilo_write_en), 32'(mon_e.hwe));
          chk($sformatf("v%0d_addr_err", mon_e.id), 32'(bus.addr_err), 32'(mon_e.aerr));
          chk($sformatf("v%0d_bus_err", mon_e.id), 32'(bus.bus_err), 32'(mon_e.berr));
          if (mon_e.full) begin
            chk($sformatf("v%0d_data_out", mon_e.id), bus.data_out, mon_e.data);
            chk($sformatf("v%0d_reg_addr", mon_e.id), 32'(bus.reg_addr_out), 32'(mon_e.raddr));
            chk($sformatf("v%0d_hi", mon_e.id), bus.hi_out, mon_e.hi);
            chk($sformatf("v%0d_lo", mon_e.id), bus.lo_out, mon_e.lo);
          end
        end
      end else begin
        chk("bubble_flags", 32'({bus.reg_write_en_out, bus.hilo_write_en, bus.addr_err, bus.bus_err}), 32'h0);
      end
    end
  end

  // starts anywhere away from posedge, returns at the negedge of the cycle that carries out_valid
  task automatic run_vec(input vec_t v, input int id);
    exp_t e;
    int   nb;
    e.id = id; e.data = v.edata; e.hi = v.hi; e.lo = v.lo; e.raddr = v.ra;
    e.rwe = v.erwe; e.hwe = v.ehwe; e.aerr = v.eaerr; e.berr = v.eberr; e.full = v.full;
    exp_q.push_back(e);
    bus.in_valid = 1'b1; bus.mem_op_in = v.op; bus.mem_addr_in = v.addr;
    bus.mem_write_data_in = v.wd; bus.data_in = v.din; bus.reg_write_en_in = v.rwe;
    bus.reg_addr_in = v.ra; bus.hilo_write_en_in = v.hwe; bus.hi_in = v.hi; bus.lo_in = v.lo;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.mem_op_in = 4'b0000;
    nb = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == v.ack_at) begin
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = v.rdata;
      end
      @(negedge clk);
      if (!bus.stall_out) break;
      nb++;
      chk($sformatf("v%0d_req", id), 32'(bus.dmem_req), 32'h1);
      chk($sformatf("v%0d_we", id), 32'(bus.dmem_we), 32'(v.ewe));
      chk($sformatf("v%0d_be", id), 32'(bus.dmem_be), 32'(v.ebe));
      chk($sformatf("v%0d_addr", id), bus.dmem_addr, v.eaddr);
      chk($sformatf("v%0d_wdata", id), bus.dmem_wdata, v.ewd);
      @(posedge clk); #1;
      bus.dmem_ack   = 1'b0;
      bus.dmem_rdata = 32'h5A5A_5A5A;
    end
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h5A5A_5A5A;
    chk($sformatf("v%0d_stall_cycles", id), 32'(nb), 32'(v.ebusy));
    chk($sformatf("v%0d_req_idle", id), 32'(bus.dmem_req), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.data_in = '0; bus.reg_write_en_in = 1'b0; bus.reg_addr_in = '0;
    bus.mem_op_in = '0; bus.mem_addr_in = '0; bus.mem_write_data_in = '0;
    bus.hilo_write_en_in = 1'b0; bus.hi_in = '0; bus.lo_in = '0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h5A5A_5A5A;

    //         op     addr          wd            din           rwe ra     hwe hi            lo            ack rdata         be     ewd           eaddr         ewe edata         erwe ehwe aerr berr busy full
    vq.push_back(mk(4'h0, 32'h0000_0000, 32'h0,         32'h1234_5678, 1, 5'd5,  1, 32'hAAAA_0001, 32'h5555_0002, 0, 32'h0,         4'h0, 32'h0,         32'h0,         0, 32'h1234_5678, 1, 1, 0, 0, 0, 1));
    vq.push_back(mk(4'h1, 32'h0000_1003, 32'h0,         32'h0000_1003, 1, 5'd7,  0, 32'h0,         32'h0,         1, 32'h80FF_0000, 4'h8, 32'h0,         32'h0000_1000, 0, 32'hFFFF_FF80, 1, 0, 0, 0, 1, 1));
    vq.push_back(mk(4'h2, 32'h0000_1003, 32'h0,         32'h0000_1003, 1, 5'd8,  0, 32'h0,         32'h0,         2, 32'h80FF_0000, 4'h8, 32'h0,         32'h0000_1000, 0, 32'h0000_0080, 1, 0, 0, 0, 2, 1));
    vq.push_back(mk(4'h3, 32'h0000_2002, 32'h0,         32'h0000_2002, 1, 5'd9,  0, 32'h0,         32'h0,         1, 32'h8001_0000, 4'hC, 32'h0,         32'h0000_2000, 0, 32'hFFFF_8001, 1, 0, 0, 0, 1, 1));
    vq.push_back(mk(4'h4, 32'h0000_2000, 32'h0,         32'h0000_2000, 1, 5'd10, 0, 32'h0,         32'h0,         1, 32'h1234_F00D, 4'h3, 32'h0,         32'h0000_2000, 0, 32'h0000_F00D, 1, 0, 0, 0, 1, 1));
    vq.push_back(mk(4'h5, 32'h0000_3004, 32'h0,         32'h0000_3004, 1, 5'd11, 1, 32'h0000_0011, 32'h0000_0022, 1, 32'hDEAD_BEEF, 4'hF, 32'h0,         32'h0000_3004, 0, 32'hDEAD_BEEF, 1, 1, 0, 0, 1, 1));
    vq.push_back(mk(4'hA, 32'h0000_4002, 32'h0000_ABCD, 32'h0000_4002, 0, 5'd0,  0, 32'h0,         32'h0,         3, 32'h0,         4'hC, 32'hABCD_ABCD, 32'h0000_4000, 1, 32'h0000_4002, 0, 0, 0, 0, 3, 1));
    vq.push_back(mk(4'h9, 32'h0000_4001, 32'h1234_565A, 32'h0000_4001, 0, 5'd0,  0, 32'h0,         32'h0,         1, 32'h0,         4'h2, 32'h5A5A_5A5A, 32'h0000_4000, 1, 32'h0000_4001, 0, 0, 0, 0, 1, 1));
    vq.push_back(mk(4'h5, 32'h0000_5002, 32'h0,         32'h0000_5002, 1, 5'd12, 1, 32'h0,         32'h0,         1, 32'h0,         4'h0, 32'h0,         32'h0,         0, 32'h0,         0, 0, 1, 0, 0, 0));
    vq.push_back(mk(4'h3, 32'h0000_5001, 32'h0,         32'h0000_5001, 1, 5'd13, 1, 32'h0,         32'h0,         1, 32'h0,         4'h0, 32'h0,         32'h0,         0, 32'h0,         0, 0, 1, 0, 0, 0));
    vq.push_back(mk(4'hB, 32'h0000_6000, 32'hCAFE_F00D, 32'h0000_6000, 0, 5'd0,  0, 32'h0,         32'h0,         0, 32'h0,         4'hF, 32'hCAFE_F00D, 32'h0000_6000, 1, 32'h0,         0, 0, 0, 1, 4, 0));
    vq.push_back(mk(4'hB, 32'h0000_6000, 32'hCAFE_F00D, 32'h0000_6000, 0, 5'd0,  0, 32'h0,         32'h0,         4, 32'h0,         4'hF, 32'hCAFE_F00D, 32'h0000_6000, 1, 32'h0000_6000, 0, 0, 0, 0, 4, 1));
    vq.push_back(mk(4'h1, 32'h0000_1000, 32'h0,         32'h0000_1000, 1, 5'd14, 0, 32'h0,         32'h0,         1, 32'h0000_007F, 4'h1, 32'h0,         32'h0000_1000, 0, 32'h0000_007F, 1, 0, 0, 0, 1, 1));

    repeat (2) @(negedge clk);
    chk("reset_stall", 32'(bus.stall_out), 32'h0);
    chk("reset_req", 32'(bus.dmem_req), 32'h0);
    chk("reset_be", 32'(bus.dmem_be), 32'h0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
    chk("reset_data_out", bus.data_out, 32'h0);
    chk("reset_errs", 32'({bus.addr_err, bus.bus_err}), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    foreach (vq[i]) run_vec(vq[i], i);

    // reset while a word load is outstanding
    bus.in_valid = 1'b1; bus.mem_op_in = 4'b0101; bus.mem_addr_in = 32'h0000_7000;
    bus.reg_write_en_in = 1'b1; bus.reg_addr_in = 5'd3;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.mem_op_in = 4'b0000;
    @(negedge clk);
    chk("rstbusy_stall_before", 32'(bus.stall_out), 32'h1);
    chk("rstbusy_req_before", 32'(bus.dmem_req), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("rstbusy_stall_async", 32'(bus.stall_out), 32'h0);
    chk("rstbusy_req_async", 32'(bus.dmem_req), 32'h0);
    chk("rstbusy_be_async", 32'(bus.dmem_be), 32'h0);
    @(negedge clk);
    bus.dmem_ack = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    bus.dmem_ack = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstbusy_stall_after", 32'(bus.stall_out), 32'h0);

    run_vec(vq[0], 99);
    repeat (3) @(negedge clk);
    chk("exp_queue_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
